seq_pattern_gen: RTL

//   Serial bit-pattern transmitter: the generating end of the serial sequence-detector path.

---
 rtl/seq_pattern_gen_if.sv | 24 ++
 rtl/seq_pattern_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen_if.sv
// Handshake and serial-output bundle for seq_pattern_gen.
// master drives the job request; slave is the generator.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             seq_out;
    logic             seq_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_n,
        input  seq_out, seq_valid, busy, done
    );

    modport slave (
        input  start, pattern, repeat_n,
        output seq_out, seq_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first, repeat_n+1 times
// with GAP idle cycles between frames. Define SEQ_GEN_PARITY_EN to append an even-parity bit per frame.
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_gen_if.slave  bus
);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_TOP = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

`ifdef SEQ_GEN_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SEND, GAPW, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             par_q, par_d;
    logic             seq_out_q, seq_out_d;
    logic             seq_valid_q, seq_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_new, reload;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        pat_d       = pat_q;
        rep_d       = rep_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        par_d       = par_q;
        seq_out_d   = 1'b0;
        seq_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        load_new    = 1'b0;
        reload      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load_new = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (bit_q != '0) begin
                    shift_d     = shift_q << 1;
                    bit_d       = bit_q - BIT_W'(1);
                    seq_out_d   = shift_q[WIDTH-2];
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (PARITY_EN && !par_q) begin
                    par_d       = 1'b1;
                    seq_out_d   = ^pat_q;
                    seq_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (rep_q != '0) begin
                    // Counter holds frames still to send, so the max value never wraps.
                    rep_d = rep_q - CNT_W'(1);
                    if (GAP == 0) begin
                        reload = 1'b1;
                    end else begin
                        state_d = GAPW;
                        gap_d   = GAP_TOP;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            GAPW: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    reload = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Repeated frames come from the latched copy, never from the live port.
        if (load_new || reload) begin
            state_d     = SEND;
            bit_d       = BIT_TOP;
            par_d       = 1'b0;
            seq_valid_d = 1'b1;
            busy_d      = 1'b1;
            if (load_new) begin
                pat_d     = bus.pattern;
                rep_d     = bus.repeat_n;
                shift_d   = bus.pattern;
                seq_out_d = bus.pattern[WIDTH-1];
            end else begin
                shift_d   = pat_q;
                seq_out_d = pat_q[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            pat_q       <= '0;
            rep_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            par_q       <= 1'b0;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            pat_q       <= pat_d;
            rep_q       <= rep_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            par_q       <= par_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.seq_out   = seq_out_q;
    assign bus.seq_valid = seq_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
